// File: rtl/dds_cmd_pkg.sv
// dds_cmd_pkg: shared constants and state encodings for the DDS command parser.
// Contents: frame sync byte, fetch/frame FSM state types, error counter width.
package dds_cmd_pkg;

  localparam logic [7:0] DDS_SYNC_BYTE = 8'hA5;
  localparam int         ERR_CNT_W     = 8;

  typedef enum logic [1:0] {
    F_REQ,
    F_ACK,
    F_WAIT,
    F_HOLD
  } fetch_state_t;

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    LEN,
    DATA,
    CSUM,
    OUT
  } frame_state_t;

endpackage

// File: rtl/fifo_byte_fetch.sv
// fifo_byte_fetch: pops one byte at a time from the byte FIFO read port.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   hold        stalls the next request while the parser cannot take a byte
//   rd_done     FIFO read_done (changes on negedge clk, hence the two flops)
//   rd_data     FIFO dout, valid once rd_done has returned high
//   rd_req      one-cycle read strobe
//   byte_q      last fetched byte
//   byte_vld    one-cycle strobe qualifying byte_q
module fifo_byte_fetch
  import dds_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       rd_done,
  input  logic [7:0] rd_data,
  output logic       rd_req,
  output logic [7:0] byte_q,
  output logic       byte_vld
);

  logic         rd_done_p0;
  logic         rd_done_s;
  logic         primed;
  fetch_state_t state;

  // Synchronizer is deliberately not reset: it must keep reporting a FIFO
  // request that was left pending across a reset.
  always_ff @(posedge clk) begin
    rd_done_p0 <= rd_done;
    rd_done_s  <= rd_done_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= F_REQ;
      primed   <= 1'b0;
      rd_req   <= 1'b0;
      byte_q   <= 8'h00;
      byte_vld <= 1'b0;
    end else begin
      rd_req   <= 1'b0;
      byte_vld <= 1'b0;
      if (!primed) begin
        // First cycle after reset: drain a request still pending in the FIFO.
        primed <= 1'b1;
        state  <= rd_done_s ? F_REQ : F_ACK;
      end else begin
        unique case (state)
          F_REQ: begin
            rd_req <= 1'b1;
            state  <= F_ACK;
          end
          F_ACK: if (!rd_done_s) state <= F_WAIT;
          F_WAIT: begin
            if (rd_done_s) begin
              byte_q   <= rd_data;
              byte_vld <= 1'b1;
              state    <= F_HOLD;
            end
          end
          // Wait one cycle past byte_vld so hold reflects the frame FSM's
          // reaction to this byte (e.g. entry into OUT).
          F_HOLD: if (!byte_vld && !hold) state <= F_REQ;
          default: state <= F_REQ;
        endcase
      end
    end
  end

endmodule

// File: rtl/dds_cmd_parser.sv
// dds_cmd_parser: assembles MCU command frames from the byte FIFO and emits
// one register write per valid frame.
// Frame: A5, addr, len (1..DATA_BYTES), len data bytes MSB-first, [checksum].
// Build option: define DDS_CMD_CHECKSUM_EN to expect a trailing XOR checksum
// over addr, len and data bytes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_req/rd_done/rd_data  FIFO read side
//   wr_valid/wr_ready/wr_addr/wr_data  register write handshake
//   frame_err           one-cycle pulse per aborted frame
//   err_cnt             saturating aborted-frame count
//   busy                frame FSM is not in HUNT
module dds_cmd_parser
  import dds_cmd_pkg::*;
#(
  parameter int          DATA_BYTES = 4,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    rd_req,
  input  logic                    rd_done,
  input  logic [7:0]              rd_data,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [7:0]              wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    frame_err,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  output logic                    busy
);

  localparam int         DW      = 8 * DATA_BYTES;
  localparam logic [7:0] MAX_LEN = 8'(DATA_BYTES);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  frame_state_t  state;
  logic [7:0]    byte_q;
  logic          byte_vld;
  logic          hold;
  logic [DW-1:0] shift;
  logic [DW-1:0] shift_nxt;
  logic [7:0]    cnt;
  logic [15:0]   gap;
  logic          in_frame;
  logic          timed_out;
`ifdef DDS_CMD_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign hold      = (state == OUT) && !(wr_valid && wr_ready);
  assign busy      = (state != HUNT);
  assign in_frame  = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CSUM);
  assign timed_out = in_frame && !byte_vld && (gap == TIMEOUT - 16'd1);
  assign shift_nxt = (shift << 8) | DW'(byte_q);

  fifo_byte_fetch u_fetch (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .rd_done  (rd_done),
    .rd_data  (rd_data),
    .rd_req   (rd_req),
    .byte_q   (byte_q),
    .byte_vld (byte_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      wr_valid  <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      shift     <= '0;
      cnt       <= 8'h00;
      gap       <= 16'h0000;
`ifdef DDS_CMD_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      frame_err <= 1'b0;
      gap       <= (in_frame && !byte_vld) ? gap + 16'd1 : 16'd0;
      if (timed_out) begin
        state     <= HUNT;
        frame_err <= 1'b1;
        err_cnt   <= sat_inc(err_cnt);
      end else begin
        unique case (state)
          HUNT: if (byte_vld && byte_q == DDS_SYNC_BYTE) state <= ADDR;
          ADDR: begin
            if (byte_vld) begin
              wr_addr <= byte_q;
`ifdef DDS_CMD_CHECKSUM_EN
              csum    <= byte_q;
`endif
              state   <= LEN;
            end
          end
          LEN: begin
            if (byte_vld) begin
              if (byte_q >= 8'd1 && byte_q <= MAX_LEN) begin
                cnt   <= byte_q;
                shift <= '0;
`ifdef DDS_CMD_CHECKSUM_EN
                csum  <= csum ^ byte_q;
`endif
                state <= DATA;
              end else begin
                state     <= HUNT;
                frame_err <= 1'b1;
                err_cnt   <= sat_inc(err_cnt);
              end
            end
          end
          DATA: begin
            if (byte_vld) begin
              shift <= shift_nxt;
              cnt   <= cnt - 8'd1;
`ifdef DDS_CMD_CHECKSUM_EN
              csum  <= csum ^ byte_q;
              if (cnt == 8'd1) state <= CSUM;
`else
              if (cnt == 8'd1) begin
                state    <= OUT;
                wr_valid <= 1'b1;
                wr_data  <= shift_nxt;
              end
`endif
            end
          end
`ifdef DDS_CMD_CHECKSUM_EN
          CSUM: begin
            if (byte_vld) begin
              if (byte_q == csum) begin
                state    <= OUT;
                wr_valid <= 1'b1;
                wr_data  <= shift;
              end else begin
                state     <= HUNT;
                frame_err <= 1'b1;
                err_cnt   <= sat_inc(err_cnt);
              end
            end
          end
`endif
          OUT: begin
            if (wr_ready) begin
              wr_valid <= 1'b0;
              state    <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_cmd_parser.sv
module tb_dds_cmd_parser;
  import dds_cmd_pkg::*;

  localparam int          DB = 4;
  localparam logic [15:0] TO = 16'd200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req;
  logic          rd_done = 1'b1;
  logic [7:0]    rd_data = 8'h00;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [7:0]    wr_addr;
  logic [8*DB-1:0] wr_data;
  logic          frame_err;
  logic [7:0]    err_cnt;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];
  bit         pend = 1'b0;
  int         dly  = 0;
  int         wr_cnt = 0, ferr_cnt = 0, req_cnt = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_data = 32'h0;
  int         exp_err = 0;

  dds_cmd_parser #(.DATA_BYTES(DB), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_done   (rd_done),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // FIFO read-side model (updates on negedge) plus output monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) begin
        wr_cnt++;
        last_addr = wr_addr;
        last_data = wr_data;
      end
      if (frame_err) ferr_cnt++;
      if (rd_req) req_cnt++;
    end
    if (rd_req) begin
      rd_done = 1'b0;
      pend    = 1'b1;
      dly     = 2;
    end else if (pend) begin
      if (dly != 0) dly--;
      else if (fifo_q.size() != 0) begin
        rd_data = fifo_q.pop_front();
        rd_done = 1'b1;
        pend    = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] addr, input int len, input logic [31:0] data, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(addr);
    fifo_q.push_back(8'(len));
    cs = addr ^ 8'(len);
    for (int i = 0; i < len; i++) begin
      b  = data[8*(len-1-i) +: 8];
      cs = cs ^ b;
      fifo_q.push_back(b);
    end
`ifdef DDS_CMD_CHECKSUM_EN
    fifo_q.push_back(bad ? (cs ^ 8'h01) : cs);
`else
    if (bad) fifo_q.push_back(cs);
`endif
  endtask

  task automatic run_idle(input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || busy || wr_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bound"}, 32'(n < 3000), 32'd1);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int w0, f0, r0, n;
    logic [7:0]  a0;
    logic [31:0] d0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Good 4-byte frame
    w0 = wr_cnt; f0 = ferr_cnt;
    send(8'h10, 4, 32'h12345678, 1'b0);
    run_idle("t1");
    chk("t1_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t1_addr", 32'(last_addr), 32'h10);
    chk("t1_data", last_data, 32'h12345678);
    chk("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("t1_err_cnt", 32'(err_cnt), 32'(exp_err));

`ifdef DDS_CMD_CHECKSUM_EN
    // Corrupted checksum
    w0 = wr_cnt; f0 = ferr_cnt;
    send(8'h10, 4, 32'h12345678, 1'b1);
    run_idle("t2");
    exp_err++;
    chk("t2_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t2_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt), 32'(exp_err));
`endif

    // Garbage before sync, A5 as data
    w0 = wr_cnt; f0 = ferr_cnt;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    send(8'h20, 1, 32'h000000A5, 1'b0);
    run_idle("t3");
    chk("t3_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t3_addr", 32'(last_addr), 32'h20);
    chk("t3_data", last_data, 32'h000000A5);
    chk("t3_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Bad length, then a good frame
    w0 = wr_cnt; f0 = ferr_cnt;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h10);
    fifo_q.push_back(8'h05);
    send(8'h30, 2, 32'h0000BEEF, 1'b0);
    run_idle("t4");
    exp_err++;
    chk("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("t4_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t4_addr", 32'(last_addr), 32'h30);
    chk("t4_data", last_data, 32'h0000BEEF);

    // Inter-byte timeout: FIFO runs dry after A5 10
    w0 = wr_cnt; f0 = ferr_cnt;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h10);
    n = 0;
    while (fifo_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("t5_busy_mid", 32'(busy), 32'd1);
    chk("t5_ferr_mid", 32'(ferr_cnt - f0), 32'd0);
    repeat (int'(TO) + 20) @(negedge clk);
    exp_err++;
    chk("t5_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_err_cnt", 32'(err_cnt), 32'(exp_err));
    // Late byte lands in HUNT and is dropped; next frame is accepted
    fifo_q.push_back(8'h04);
    send(8'h40, 1, 32'h0000005A, 1'b0);
    run_idle("t5b");
    chk("t5_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t5_addr", 32'(last_addr), 32'h40);
    chk("t5_data", last_data, 32'h0000005A);
    chk("t5_ferr_after", 32'(ferr_cnt - f0), 32'd1);

    // Backpressure in OUT
    @(posedge clk); #1 wr_ready = 1'b0;
    w0 = wr_cnt;
    send(8'h55, 2, 32'h0000CAFE, 1'b0);
    fifo_q.push_back(8'h00);
    n = 0;
    while (!wr_valid && n < 500) begin @(negedge clk); n++; end
    chk("t6_valid_bound", 32'(n < 500), 32'd1);
    r0 = req_cnt; a0 = wr_addr; d0 = wr_data;
    chk("t6_addr", 32'(a0), 32'h55);
    chk("t6_data", d0, 32'h0000CAFE);
    repeat (20) @(negedge clk);
    chk("t6_valid_held", 32'(wr_valid), 32'd1);
    chk("t6_addr_held", 32'(wr_addr), 32'(a0));
    chk("t6_data_held", wr_data, d0);
    chk("t6_no_req", 32'(req_cnt - r0), 32'd0);
    chk("t6_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("t6_fifo_left", 32'(fifo_q.size()), 32'd1);
    @(posedge clk); #1 wr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_write", 32'(wr_cnt - w0), 32'd1);
    chk("t6_valid_drop", 32'(wr_valid), 32'd0);
    run_idle("t6");
    chk("t6_final_err", 32'(err_cnt), 32'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
